rv64_iter_divider: RTL and testbench

- Multi-cycle RV64M divide/remainder unit; ops DIV, DIVU, REM, REMU and their W forms.
- Sits beside EX in the CPU. Takes operands from ID/register read, iterates one quotient bit per cycle, then holds the result in an output stage until writeback accepts it.
- Exposes in-flight and completed destination registers so the register file can detect hazards.

---
 rtl/rv64_iter_divider.sv | 194 +++++++++++++++++++
 tb/tb_rv64_iter_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rv64_iter_divider.sv
// Multi-cycle RV64M divide/remainder unit: restoring divide, one quotient bit per cycle, with a held output stage.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed-overflow ops bypass iteration.
module rv64_iter_divider #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            block,
  input  logic            valid_in,
  input  logic            error_in,
  input  logic [XLEN-1:0] nxtpc_in,
  input  logic [XLEN-1:0] src1_in,
  input  logic [XLEN-1:0] src2_in,
  input  logic [1:0]      ALUctr_in,
  input  logic            is_w_in,
  input  logic [RD_W-1:0] rd_in,
  output logic            ready,
  output logic            valid_part,
  output logic [RD_W-1:0] rd_part,
  output logic            valid,
  output logic [RD_W-1:0] rd,
  output logic [XLEN-1:0] result,
  output logic            error,
  output logic [XLEN-1:0] nxtpc
);

  localparam int unsigned HALF = XLEN / 2;
  localparam int unsigned CW   = $clog2(XLEN) + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, div_q, a_q, pc_q;
  logic            w_q, rem_op_q, q_neg_q, r_neg_q, dz_q, ovf_q, err_q;

  // Operand conditioning at accept
  logic            sgn_in, a_neg, b_neg, dz_in, ovf_in;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b;

  always_comb begin
    sgn_in = ~ALUctr_in[0];
    if (is_w_in) begin
      a_ext = sgn_in ? {{HALF{src1_in[HALF-1]}}, src1_in[HALF-1:0]} : {{HALF{1'b0}}, src1_in[HALF-1:0]};
      b_ext = sgn_in ? {{HALF{src2_in[HALF-1]}}, src2_in[HALF-1:0]} : {{HALF{1'b0}}, src2_in[HALF-1:0]};
    end else begin
      a_ext = src1_in;
      b_ext = src2_in;
    end
    a_neg  = sgn_in & a_ext[XLEN-1];
    b_neg  = sgn_in & b_ext[XLEN-1];
    abs_a  = a_neg ? -a_ext : a_ext;
    abs_b  = b_neg ? -b_ext : b_ext;
    dz_in  = (b_ext == '0);
    ovf_in = sgn_in && (b_ext == '1) &&
             (is_w_in ? (a_ext == {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}})
                      : (a_ext == {1'b1, {(XLEN-1){1'b0}}}));
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  logic [XLEN:0]   sh;
  logic            ge;
  logic [XLEN-1:0] rem_next;

  always_comb begin
    sh       = {rem_q, quo_q[XLEN-1]};
    ge       = (sh >= {1'b0, div_q});
    rem_next = XLEN'(ge ? (sh - {1'b0, div_q}) : sh);
  end

  // Final sign fix-up and special-case override
  logic [XLEN-1:0] q_mag, r_mag, q_fin, r_fin, res_sel, res_fin;

  always_comb begin
    q_mag = w_q ? {{HALF{1'b0}}, quo_q[HALF-1:0]} : quo_q;
    r_mag = rem_q;
    q_fin = q_neg_q ? -q_mag : q_mag;
    r_fin = r_neg_q ? -r_mag : r_mag;
    if (dz_q) begin
      q_fin = '1;
      r_fin = a_q;
    end else if (ovf_q) begin
      q_fin = a_q;
      r_fin = '0;
    end
    res_sel = rem_op_q ? r_fin : q_fin;
    res_fin = w_q ? {{HALF{res_sel[HALF-1]}}, res_sel[HALF-1:0]} : res_sel;
  end

  // Control
  logic          accept, step, move, out_free, fast, done;
  logic [CW-1:0] n_bits;

  always_comb begin
    n_bits   = w_q ? CW'(HALF) : CW'(XLEN);
    out_free = ~valid | ~block;
    fast     = 1'b0;
`ifdef DIV_FASTPATH_EN
    fast     = dz_q | ovf_q;
`endif
    done     = fast || (cnt_q == n_bits);
    accept   = 1'b0;
    step     = 1'b0;
    move     = 1'b0;
    state_d  = state_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          accept  = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!done) begin
          step = 1'b1;
        end else if (out_free) begin
          move    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign valid_part = (state_q == S_BUSY);
  assign ready      = ~valid_part;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      a_q      <= '0;
      pc_q     <= '0;
      w_q      <= 1'b0;
      rem_op_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_part  <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      quo_q    <= is_w_in ? {abs_a[HALF-1:0], {HALF{1'b0}}} : abs_a;
      rem_q    <= '0;
      div_q    <= abs_b;
      a_q      <= a_ext;
      pc_q     <= nxtpc_in;
      w_q      <= is_w_in;
      rem_op_q <= ALUctr_in[1];
      q_neg_q  <= a_neg ^ b_neg;
      r_neg_q  <= a_neg;
      dz_q     <= dz_in;
      ovf_q    <= ovf_in;
      err_q    <= error_in;
      rd_part  <= rd_in;
    end else if (step) begin
      cnt_q <= cnt_q + CW'(1);
      quo_q <= {quo_q[XLEN-2:0], ge};
      rem_q <= rem_next;
    end else if (move) begin
      rd_part <= '0;
    end
  end

  // Output stage; result reads as zero whenever valid is low
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid  <= 1'b0;
      rd     <= '0;
      result <= '0;
      error  <= 1'b0;
      nxtpc  <= '0;
    end else if (move) begin
      valid  <= 1'b1;
      rd     <= rd_part;
      result <= res_fin;
      error  <= err_q;
      nxtpc  <= pc_q;
    end else if (valid && !block) begin
      valid  <= 1'b0;
      result <= '0;
    end
  end

endmodule

// File: tb/tb_rv64_iter_divider.sv
// Randomized self-checking bench for rv64_iter_divider against an arithmetic reference model.
module tb_rv64_iter_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        block = 1'b0;
  logic        valid_in = 1'b0;
  logic        error_in = 1'b0;
  logic [63:0] nxtpc_in = '0;
  logic [63:0] src1_in = '0;
  logic [63:0] src2_in = '0;
  logic [1:0]  ALUctr_in = '0;
  logic        is_w_in = 1'b0;
  logic [4:0]  rd_in = '0;
  logic        ready, valid_part, valid, error;
  logic [4:0]  rd_part, rd;
  logic [63:0] result, nxtpc;

  int unsigned checks = 0;
  int unsigned errors = 0;

  rv64_iter_divider #(.XLEN(64), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .block(block), .valid_in(valid_in), .error_in(error_in),
    .nxtpc_in(nxtpc_in), .src1_in(src1_in), .src2_in(src2_in), .ALUctr_in(ALUctr_in),
    .is_w_in(is_w_in), .rd_in(rd_in), .ready(ready), .valid_part(valid_part),
    .rd_part(rd_part), .valid(valid), .rd(rd), .result(result), .error(error), .nxtpc(nxtpc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] c, input logic w);
    longint      sa, sb, q, r;
    logic [63:0] uq, ur, res;
    logic        sgn = ~c[0];
    if (w) begin
      sa = sgn ? longint'($signed(a[31:0])) : longint'({32'b0, a[31:0]});
      sb = sgn ? longint'($signed(b[31:0])) : longint'({32'b0, b[31:0]});
      if (sb == 0) begin q = -1; r = sa; end
      else begin q = sa / sb; r = sa % sb; end
      res = c[1] ? r : q;
      return {{32{res[31]}}, res[31:0]};
    end
    if (sgn) begin
      sa = longint'(a);
      sb = longint'(b);
      if (sb == 0) begin q = -1; r = sa; end
      else if (a == 64'h8000_0000_0000_0000 && b == '1) begin q = sa; r = 0; end
      else begin q = sa / sb; r = sa % sb; end
      res = c[1] ? r : q;
      return res;
    end
    if (b == 0) begin uq = '1; ur = a; end
    else begin uq = a / b; ur = a % b; end
    return c[1] ? ur : uq;
  endfunction

  function automatic int unsigned latency(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] c, input logic w);
    logic special;
    if (w) special = (b[31:0] == 0) || (!c[0] && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
    else   special = (b == 0) || (!c[0] && a == 64'h8000_0000_0000_0000 && b == '1);
`ifdef DIV_FASTPATH_EN
    if (special) return 1;
`else
    if (special) return w ? 33 : 65;
`endif
    return w ? 33 : 65;
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                       input logic w, input logic [4:0] r, input logic [63:0] pc, input logic e);
    @(negedge clk);
    src1_in = a; src2_in = b; ALUctr_in = c; is_w_in = w; rd_in = r; nxtpc_in = pc; error_in = e;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 0;
    while (!valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                       input logic w, input logic [4:0] r, input logic [63:0] pc, input logic e);
    int unsigned n;
    issue(a, b, c, w, r, pc, e);
    check("busy_vp", {63'b0, valid_part}, 64'd1);
    check("busy_ready", {63'b0, ready}, 64'd0);
    check("busy_rd_part", {59'b0, rd_part}, {59'b0, r});
    wait_valid(n);
    check("latency", 64'(n), 64'(latency(a, b, c, w)));
    check("result", result, model(a, b, c, w));
    check("rd", {59'b0, rd}, {59'b0, r});
    check("nxtpc", nxtpc, pc);
    check("error", {63'b0, error}, {63'b0, e});
    @(posedge clk);
    #1;
    check("drained_valid", {63'b0, valid}, 64'd0);
    check("drained_result", result, 64'd0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 20));
      2: return 64'd0;
      3: return '1;
      4: return 64'h8000_0000_0000_0000;
      5: return {{32{1'b1}}, 32'h8000_0000};
      default: return {32'($urandom), 32'($urandom)} ^ 64'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    int unsigned n;
    logic        saw;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'b0, ready}, 64'd1);
    check("rst_vp", {63'b0, valid_part}, 64'd0);
    check("rst_valid", {63'b0, valid}, 64'd0);
    check("rst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'b00, 1'b0, 5'd5, 64'h8000_0004, 1'b0);
    do_op(64'h0000_0001_8000_0001, 64'd3, 2'b10, 1'b1, 5'd6, 64'h100, 1'b1);
    do_op(64'd100, 64'd0, 2'b01, 1'b0, 5'd7, 64'h104, 1'b0);
    do_op(64'd100, 64'd0, 2'b11, 1'b0, 5'd8, 64'h108, 1'b0);
    do_op(64'h8000_0000_0000_0000, '1, 2'b00, 1'b0, 5'd9, 64'h10C, 1'b0);
    do_op(64'h8000_0000_0000_0000, '1, 2'b10, 1'b0, 5'd10, 64'h110, 1'b0);
    do_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1, 5'd11, 64'h114, 1'b0);
    do_op(64'h1234_5678_0000_0000, 64'hABCD_0000_0000_0000, 2'b01, 1'b1, 5'd12, 64'h118, 1'b0);
    do_op('1, 64'd1, 2'b01, 1'b0, 5'd13, 64'h11C, 1'b0);
    do_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 2'b10, 1'b0, 5'd14, 64'h120, 1'b0);

    for (int i = 0; i < 30; i++) begin
      do_op(pick(), pick(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(1, 31)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    // Output stage held by block while a second op finishes behind it
    block = 1'b1;
    issue(64'd1000, 64'd7, 2'b01, 1'b0, 5'd3, 64'h200, 1'b0);
    wait_valid(n);
    check("b2b_lat1", 64'(n), 64'd65);
    check("b2b_res1", result, 64'd142);
    issue(-64'sd1000, 64'd7, 2'b10, 1'b0, 5'd9, 64'h204, 1'b1);
    repeat (70) @(posedge clk);
    #1;
    check("b2b_hold_valid", {63'b0, valid}, 64'd1);
    check("b2b_hold_res", result, 64'd142);
    check("b2b_hold_rd", {59'b0, rd}, 64'd3);
    check("b2b_hold_vp", {63'b0, valid_part}, 64'd1);
    check("b2b_hold_ready", {63'b0, ready}, 64'd0);
    @(negedge clk);
    block = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_swap_valid", {63'b0, valid}, 64'd1);
    check("b2b_swap_res", result, model(-64'sd1000, 64'd7, 2'b10, 1'b0));
    check("b2b_swap_rd", {59'b0, rd}, 64'd9);
    check("b2b_swap_err", {63'b0, error}, 64'd1);
    check("b2b_swap_vp", {63'b0, valid_part}, 64'd0);
    @(posedge clk);
    #1;
    check("b2b_drain", {63'b0, valid}, 64'd0);

    // Abort mid-iteration
    issue(64'd12345, 64'd11, 2'b01, 1'b0, 5'd4, 64'h300, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_vp", {63'b0, valid_part}, 64'd0);
    check("abort_ready", {63'b0, ready}, 64'd1);
    check("abort_valid", {63'b0, valid}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      saw |= valid;
    end
    check("abort_no_result", {63'b0, saw}, 64'd0);

    do_op(64'd12345, 64'd11, 2'b11, 1'b0, 5'd4, 64'h304, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
